// File: rtl/cpu_bus_mux_if.sv
// rtl/cpu_bus_mux_if.sv - CPU strobe/decode bundle between a Z80-style CPU and the channel mux
interface cpu_bus_mux_if #(
  parameter int NCH    = 4,
  parameter int WAIT_W = 3
);
  logic                    ce;
  logic                    iorq;
  logic                    mreq;
  logic                    rd;
  logic                    wr;
  logic                    m1;
  logic [15:0]             addr;
  logic [NCH*16-1:0]       match_addr;
  logic [NCH*16-1:0]       match_mask;
  logic [NCH-1:0]          match_io;
  logic [NCH*WAIT_W-1:0]   ch_wait;
  logic [NCH*8-1:0]        ch_data;
  logic                    conflict_clr;
  logic [NCH-1:0]          ch_sel;
  logic [7:0]              dout;
  logic                    wait_n;
  logic                    hit;
  logic                    conflict;

  modport master (
    output ce, iorq, mreq, rd, wr, m1, addr,
    output match_addr, match_mask, match_io, ch_wait, ch_data, conflict_clr,
    input  ch_sel, dout, wait_n, hit, conflict
  );

  modport slave (
    input  ce, iorq, mreq, rd, wr, m1, addr,
    input  match_addr, match_mask, match_io, ch_wait, ch_data, conflict_clr,
    output ch_sel, dout, wait_n, hit, conflict
  );
endinterface

// File: rtl/cpu_bus_mux.sv
// rtl/cpu_bus_mux.sv - address decoder, wait-state generator and read-data mux for CPU slave channels
module cpu_bus_mux #(
  parameter int         NCH    = 4,
  parameter int         WAIT_W = 3,
  parameter logic [7:0] FLOAT  = 8'hFF
) (
  input  logic         clk,
  input  logic         reset_n,
  cpu_bus_mux_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACT} state_t;

  state_t            state_q;
  logic [WAIT_W-1:0] cnt_q;
  logic [NCH-1:0]    ch_sel_q;
  logic [7:0]        dout_q;
  logic              wait_n_q;
  logic              hit_q;
  logic              conflict_q;
  logic              armed_q;

  logic [NCH-1:0]    match;
  logic [NCH-1:0]    sel_d;
  logic [WAIT_W-1:0] wait_d;
  logic [7:0]        rd_data;
  int                nmatch;
  logic              strobe;
  logic              start;
  logic              inta;

  always_comb begin
    match = '0;
    for (int i = 0; i < NCH; i++) begin
      match[i] = (((bus.addr ^ bus.match_addr[16*i +: 16]) & bus.match_mask[16*i +: 16]) == 16'h0000)
                 && ((bus.iorq && bus.match_io[i]) || (bus.mreq && !bus.match_io[i]));
    end
  end

  // Scan downward so the lowest-index matching channel is the last one written.
  always_comb begin
    sel_d  = '0;
    wait_d = '0;
    nmatch = 0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (match[i]) begin
        sel_d    = '0;
        sel_d[i] = 1'b1;
        wait_d   = bus.ch_wait[WAIT_W*i +: WAIT_W];
        nmatch   = nmatch + 1;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ch_sel_q[i]) rd_data = bus.ch_data[8*i +: 8];
    end
  end

  // armed_q blocks decoding of a cycle already in progress when reset releases.
  assign strobe = bus.iorq || bus.mreq;
  assign start  = armed_q && strobe && (bus.rd || bus.wr) && !bus.m1;
  assign inta   = armed_q && bus.m1 && bus.iorq;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      ch_sel_q   <= '0;
      dout_q     <= FLOAT;
      wait_n_q   <= 1'b1;
      hit_q      <= 1'b0;
      conflict_q <= 1'b0;
      armed_q    <= 1'b0;
    end else if (bus.ce) begin
      if (bus.conflict_clr) conflict_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!strobe) armed_q <= 1'b1;
          if (inta) begin
            state_q  <= S_ACT;
            dout_q   <= FLOAT;
            ch_sel_q <= '0;
            hit_q    <= 1'b0;
          end else if (start) begin
            ch_sel_q <= sel_d;
            hit_q    <= |sel_d;
            if (nmatch > 1) conflict_q <= 1'b1;
            if (!(|sel_d)) begin
              state_q <= S_ACT;
              if (bus.rd) dout_q <= FLOAT;
            end else if (wait_d == '0) begin
              state_q <= S_ACT;
            end else begin
              state_q  <= S_WAIT;
              cnt_q    <= wait_d;
              wait_n_q <= 1'b0;
            end
          end
        end
        S_WAIT: begin
          if (!strobe) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            wait_n_q <= 1'b1;
            ch_sel_q <= '0;
            hit_q    <= 1'b0;
          end else if (cnt_q == WAIT_W'(1)) begin
            state_q  <= S_ACT;
            cnt_q    <= '0;
            wait_n_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - WAIT_W'(1);
          end
        end
        S_ACT: begin
          if (!strobe) begin
            state_q  <= S_IDLE;
            ch_sel_q <= '0;
            hit_q    <= 1'b0;
          end else if (hit_q && bus.rd) begin
            dout_q <= rd_data;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.ch_sel   = ch_sel_q;
  assign bus.dout     = dout_q;
  assign bus.wait_n   = wait_n_q;
  assign bus.hit      = hit_q;
  assign bus.conflict = conflict_q;

endmodule

// File: tb/tb_cpu_bus_mux.sv
// tb/tb_cpu_bus_mux.sv - directed and randomized bus-cycle checks against a transaction-level decode model
module tb_cpu_bus_mux;

  localparam int NCH = 8;
  localparam int WW  = 4;

  logic clk;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] c_addr [NCH];
  logic [15:0] c_mask [NCH];
  bit          c_io   [NCH];
  int          c_wait [NCH];
  logic [7:0]  c_data [NCH];
  logic [7:0]  exp_dout;
  bit          exp_conf;

  cpu_bus_mux_if #(.NCH(NCH), .WAIT_W(WW)) bus ();

  cpu_bus_mux #(.NCH(NCH), .WAIT_W(WW), .FLOAT(8'hFF)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit c);
    bus.ce = c;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_cfg();
    for (int i = 0; i < NCH; i++) begin
      bus.match_addr[16*i +: 16] = c_addr[i];
      bus.match_mask[16*i +: 16] = c_mask[i];
      bus.match_io[i]            = c_io[i];
      bus.ch_wait[WW*i +: WW]    = c_wait[i][WW-1:0];
      bus.ch_data[8*i +: 8]      = c_data[i];
    end
  endtask

  task automatic unmap_all();
    for (int i = 0; i < NCH; i++) begin
      c_addr[i] = 16'h0100 + 16'(i);
      c_mask[i] = 16'hFFFF;
      c_io[i]   = 1'b0;
      c_wait[i] = 0;
      c_data[i] = 8'(8'h10 + i);
    end
  endtask

  task automatic drop_strobes();
    bus.iorq = 0; bus.mreq = 0; bus.rd = 0; bus.wr = 0; bus.m1 = 0;
  endtask

  // One complete CPU cycle; expectations come from a list of matching channels.
  task automatic run_txn(input logic [15:0] a, input bit io, input bit is_rd, input bit inta);
    int          hits[$];
    int          owner;
    int          exp_w;
    int          n;
    int          guard;
    logic [7:0]  exp_sel;
    if (!inta)
      for (int i = 0; i < NCH; i++)
        if ((((a ^ c_addr[i]) & c_mask[i]) == 16'h0) && (c_io[i] == io)) hits.push_back(i);
    owner   = (hits.size() > 0) ? hits[0] : -1;
    exp_w   = (owner >= 0) ? c_wait[owner] : 0;
    exp_sel = (owner >= 0) ? (8'h01 << owner) : 8'h00;
    if (inta || (owner < 0 && is_rd)) exp_dout = 8'hFF;
    else if (owner >= 0 && is_rd)     exp_dout = c_data[owner];
    if (hits.size() > 1) exp_conf = 1'b1;

    apply_cfg();
    bus.addr = a;
    bus.iorq = io || inta;
    bus.mreq = !io && !inta;
    bus.rd   = !inta && is_rd;
    bus.wr   = !inta && !is_rd;
    bus.m1   = inta;
    step(1);
    bus.addr       = 16'($urandom);
    bus.match_mask = '0;
    bus.ch_wait    = '1;

    n = 0;
    guard = 0;
    while (bus.wait_n === 1'b0 && guard < 200) begin
      if ($urandom_range(0, 3) == 0) begin
        step(0);
        chk("wait_hold_ce0", bus.wait_n, 0);
      end else begin
        step(1);
        n++;
      end
      guard++;
    end
    chk("wait_periods", n, exp_w);
    chk("ch_sel", bus.ch_sel, exp_sel);
    chk("hit", bus.hit, (owner >= 0) ? 1 : 0);
    chk("wait_n_act", bus.wait_n, 1);
    step(1);
    chk("dout", bus.dout, exp_dout);

    drop_strobes();
    step(1);
    chk("end_hit", bus.hit, 0);
    chk("end_ch_sel", bus.ch_sel, 0);
    chk("end_dout_hold", bus.dout, exp_dout);
    chk("conflict", bus.conflict, exp_conf);
    apply_cfg();
  endtask

  initial begin
    reset_n = 1'b0;
    bus.ce = 0; bus.conflict_clr = 0; bus.addr = '0;
    drop_strobes();
    unmap_all();
    apply_cfg();
    exp_dout = 8'hFF;
    exp_conf = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ch_sel", bus.ch_sel, 0);
    chk("rst_dout", bus.dout, 8'hFF);
    chk("rst_wait_n", bus.wait_n, 1);
    chk("rst_hit", bus.hit, 0);
    chk("rst_conflict", bus.conflict, 0);
    reset_n = 1'b1;
    step(1);

    // I/O read, zero waits
    c_addr[0] = 16'hBC00; c_mask[0] = 16'hFF00; c_io[0] = 1; c_wait[0] = 0; c_data[0] = 8'h5A;
    run_txn(16'hBC00, 1'b1, 1'b1, 1'b0);

    // Memory read with three wait states
    unmap_all();
    c_addr[2] = 16'h4000; c_mask[2] = 16'hFFFF; c_io[2] = 0; c_wait[2] = 3; c_data[2] = 8'hC3;
    run_txn(16'h4000, 1'b0, 1'b1, 1'b0);

    // Two channels on the same address: lowest wins, sticky conflict
    unmap_all();
    c_addr[0] = 16'hF700; c_mask[0] = 16'hFF00; c_data[0] = 8'hA1;
    c_addr[1] = 16'hF700; c_mask[1] = 16'hFF00; c_data[1] = 8'hB2;
    run_txn(16'hF700, 1'b0, 1'b1, 1'b0);
    repeat (3) step(1);
    chk("conflict_sticky", bus.conflict, 1);
    bus.conflict_clr = 1; step(1); bus.conflict_clr = 0;
    exp_conf = 1'b0;
    chk("conflict_clr", bus.conflict, 0);

    // Clear and new conflict on the same edge: set wins
    bus.conflict_clr = 1;
    bus.addr = 16'hF700; bus.mreq = 1; bus.rd = 1;
    step(1);
    bus.conflict_clr = 0;
    chk("conflict_set_wins", bus.conflict, 1);
    drop_strobes(); step(1);
    exp_dout = 8'hA1;
    bus.conflict_clr = 1; step(1); bus.conflict_clr = 0;
    exp_conf = 1'b0;

    // Unmapped read, then interrupt acknowledge after a real read
    unmap_all();
    run_txn(16'h7F00, 1'b0, 1'b1, 1'b0);
    c_addr[0] = 16'hBC00; c_mask[0] = 16'hFF00; c_io[0] = 1; c_data[0] = 8'h5A;
    run_txn(16'hBC00, 1'b1, 1'b1, 1'b0);
    run_txn(16'h00FF, 1'b1, 1'b0, 1'b1);

    // Reset in the middle of a wait
    unmap_all();
    c_addr[3] = 16'h2000; c_mask[3] = 16'hFFFF; c_wait[3] = 4; c_data[3] = 8'h77;
    apply_cfg();
    bus.addr = 16'h2000; bus.mreq = 1; bus.rd = 1;
    step(1); step(1); step(1);
    chk("mid_wait_low", bus.wait_n, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("async_wait_n", bus.wait_n, 1);
    chk("async_dout", bus.dout, 8'hFF);
    chk("async_ch_sel", bus.ch_sel, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) step(1);
    chk("post_rst_nodecode_hit", bus.hit, 0);
    chk("post_rst_nodecode_wait", bus.wait_n, 1);
    drop_strobes(); step(1);
    exp_dout = 8'hFF;
    exp_conf = 1'b0;
    run_txn(16'h2000, 1'b0, 1'b1, 1'b0);

    // Widest wait on the last channel, stretched by ce=0 cycles
    unmap_all();
    c_addr[7] = 16'h00F7; c_mask[7] = 16'hFFFF; c_io[7] = 1; c_wait[7] = 15; c_data[7] = 8'h3C;
    run_txn(16'h00F7, 1'b1, 1'b1, 1'b0);

    // Randomized cycles
    for (int t = 0; t < 40; t++) begin
      logic [15:0] a;
      a = 16'($urandom);
      for (int i = 0; i < NCH; i++) begin
        c_io[i]   = 1'($urandom_range(0, 1));
        c_mask[i] = 16'($urandom);
        c_addr[i] = ($urandom_range(0, 2) == 0) ? (a ^ (16'($urandom) & ~c_mask[i])) : 16'($urandom);
        c_wait[i] = $urandom_range(0, 3);
        c_data[i] = 8'($urandom);
      end
      run_txn(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 3) == 0) begin
        bus.conflict_clr = 1; step(1); bus.conflict_clr = 0;
        exp_conf = 1'b0;
        chk("rand_conflict_clr", bus.conflict, 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_bus_mux.md
CPU_BUS_MUX -- requirements
Module: cpu_bus_mux

Interface
REQ-001 Parameter NCH, default 4: number of decoded slave channels, legal range 1..8.
REQ-002 Parameter WAIT_W, default 3: width of the per-channel wait-state count.
REQ-003 Parameter FLOAT, default 8'hFF: value driven on dout when no channel answers.
REQ-004 clk  in  1  system clock; single clock domain.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 ce  in  1  CPU clock enable (phi_en_p); all state advances only when ce=1.
REQ-007 iorq, mreq, rd, wr, m1  in  1 each  active-high Z80 strobes.
REQ-008 addr  in  16  CPU address.
REQ-009 match_addr  in  NCH*16  per-channel compare value, channel i at bits [16i+15:16i].
REQ-010 match_mask  in  NCH*16  per-channel mask; a 1 bit participates in the compare.
REQ-011 match_io  in  NCH  1 = channel decodes I/O cycles; 0 = channel decodes memory cycles.
REQ-012 ch_wait  in  NCH*WAIT_W  wait states inserted for each channel.
REQ-013 ch_data  in  NCH*8  per-channel read data.
REQ-014 ch_sel  out  NCH  one-hot select of the active channel.
REQ-015 dout  out  8  registered read data to the CPU.
REQ-016 wait_n  out  1  active-low CPU wait request.
REQ-017 hit  out  1  high while a decoded channel owns the current cycle.
REQ-018 conflict  out  1  sticky flag: two or more channels matched one cycle.
REQ-019 conflict_clr  in  1  synchronous clear of conflict.

Function
REQ-020 Channel i matches when ((addr ^ match_addr[i]) & match_mask[i]) == 0, and either (iorq and match_io[i]) or (mreq and not match_io[i]).
REQ-021 The state machine has three states: IDLE, WAIT and ACT.
REQ-022 IDLE -> start: on ce with (iorq|mreq)&(rd|wr) and m1=0, latch the lowest-index matching channel into ch_sel.
REQ-023 On start, if the latched ch_wait value is 0, go to ACT; otherwise go to WAIT and load cnt with that value.
REQ-024 In WAIT, wait_n=0; on each ce, if cnt==1 go to ACT, else decrement cnt. This gives exactly ch_wait ce periods of wait.
REQ-025 In ACT, wait_n=1 and hit=1; on each ce with rd=1, dout <= ch_data of the selected channel.
REQ-026 From WAIT or ACT, return to IDLE on a ce where iorq=mreq=0. Clear ch_sel and hit; dout holds its last value.
REQ-027 No match at start: ch_sel=0, hit=0, no wait states, dout <= FLOAT, and the machine stays in a no-owner cycle until the strobes drop.
REQ-028 Interrupt acknowledge (m1&iorq): never decoded; dout <= FLOAT, no wait states.
REQ-029 Write cycles follow the same decode and wait path, but dout is not updated.
REQ-030 More than one match at start sets conflict; conflict holds until conflict_clr=1.
REQ-031 If conflict_clr and a new conflict occur on the same cycle, the set wins.
REQ-032 Decode inputs (addr, match_*, ch_wait) are sampled only at start; later changes do not affect the current cycle.
REQ-033 With ce=0, all registers hold their values.

Reset
REQ-034 While reset_n=0, asynchronously force: state=IDLE, cnt=0, ch_sel=0, dout=FLOAT, wait_n=1, hit=0, conflict=0.
REQ-035 If reset_n is asserted mid-cycle (WAIT or ACT), wait_n releases immediately. After reset_n rises, the still-active cycle is not decoded; decoding resumes at the next strobe rising edge.

Verification
REQ-036 I/O read, addr=16'hBC00, ch0 match_addr=16'hBC00, mask=16'hFF00, io=1, wait=0, data=8'h5A -> ch_sel=4'b0001, wait_n never 0, dout=8'h5A.
REQ-037 Memory read on ch2 with ch_wait=3 -> wait_n=0 for exactly 3 ce periods, then ACT, dout=ch2 data.
REQ-038 ch0 and ch1 both match 16'hF700 -> ch_sel=4'b0001, conflict=1 and stays 1 until conflict_clr pulses.
REQ-039 Read of unmapped addr 16'h7F00 -> hit=0, dout=8'hFF, wait_n=1; an interrupt acknowledge cycle gives dout=8'hFF.
REQ-040 reset_n pulsed low during WAIT with cnt=2 -> wait_n=1 and dout=8'hFF at once; the next strobe decodes normally.
REQ-041 NCH=8, WAIT_W=4, ch7 wait=15 -> 15 wait periods; ce held low mid-wait stretches the wait without losing count.
